// File: rtl/mccoy_instr_feeder.sv
// mccoy_instr_feeder: small program buffer that stores 6-bit instructions
// and replays them, one per clock, into the core's instruction input.
// Optional feature macro: FEEDER_LOOP_EN. When defined, replay wraps from
// the last stored entry back to entry 0 indefinitely and DONE is never
// entered. Without it, replay stops in DONE after the last entry.
module mccoy_instr_feeder #(
    parameter int         DEPTH      = 8,
    parameter logic [5:0] IDLE_INSTR = 6'b000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [5:0] wr_data,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [5:0] instr_out,
    output logic       running,
    output logic       done,
    output logic [4:0] count,
    output logic       overflow
);

    localparam int         IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t         state;
    logic [5:0]     mem [DEPTH];
    logic [IW-1:0]  rd_idx;
    logic           full;
    logic           wr_accept;
    logic           last_idx;
    logic           start_ok;

`ifndef FEEDER_LOOP_EN
    logic           last_sent;
`endif

    // Buffer status, write qualification and replay wrap point.
    // The wrap point compares against count, never DEPTH, so short
    // programs wrap (or finish) at their own length.
    always_comb begin
        full      = (count == DEPTH_CNT);
        wr_accept = (state == ST_IDLE) && wr_en && !clear && !full;
        last_idx  = (5'(rd_idx) == (count - 5'd1));
        start_ok  = start && !stop && !clear && (count != 5'd0);
    end

    // Program storage; not reset, a zero count marks every entry invalid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[count[IW-1:0]] <= wr_data;
        end
    end

    // Control FSM with registered instr_out, running and done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= 5'd0;
            rd_idx    <= '0;
            overflow  <= 1'b0;
            instr_out <= IDLE_INSTR;
            running   <= 1'b0;
            done      <= 1'b0;
`ifndef FEEDER_LOOP_EN
            last_sent <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    instr_out <= IDLE_INSTR;
                    if (clear) begin
                        count    <= 5'd0;
                        overflow <= 1'b0;
                    end else begin
                        if (wr_en) begin
                            if (full) begin
                                overflow <= 1'b1;
                            end else begin
                                count <= count + 5'd1;
                            end
                        end
                        if (start_ok) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                            done    <= 1'b0;
                            rd_idx  <= '0;
`ifndef FEEDER_LOOP_EN
                            last_sent <= 1'b0;
`endif
                        end
                    end
                end

                ST_RUN: begin
                    if (stop) begin
                        state     <= ST_IDLE;
                        running   <= 1'b0;
                        done      <= 1'b0;
                        instr_out <= IDLE_INSTR;
                    end else begin
`ifdef FEEDER_LOOP_EN
                        instr_out <= mem[rd_idx];
                        if (last_idx) begin
                            rd_idx <= '0;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
`else
                        if (last_sent) begin
                            state     <= ST_DONE;
                            running   <= 1'b0;
                            done      <= 1'b1;
                            instr_out <= IDLE_INSTR;
                            rd_idx    <= '0;
                            last_sent <= 1'b0;
                        end else begin
                            instr_out <= mem[rd_idx];
                            if (last_idx) begin
                                rd_idx    <= '0;
                                last_sent <= 1'b1;
                            end else begin
                                rd_idx <= rd_idx + 1'b1;
                            end
                        end
`endif
                    end
                end

                ST_DONE: begin
                    instr_out <= IDLE_INSTR;
                    if (clear) begin
                        state    <= ST_IDLE;
                        done     <= 1'b0;
                        count    <= 5'd0;
                        overflow <= 1'b0;
                    end else if (start_ok) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                        done    <= 1'b0;
                        rd_idx  <= '0;
`ifndef FEEDER_LOOP_EN
                        last_sent <= 1'b0;
`endif
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    running   <= 1'b0;
                    done      <= 1'b0;
                    instr_out <= IDLE_INSTR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mccoy_instr_feeder.sv
// tb_mccoy_instr_feeder: randomized scenarios for mccoy_instr_feeder,
// checked against a queue-based model of the stored program.
// Builds with or without FEEDER_LOOP_EN; the expected replay follows it.
module tb_mccoy_instr_feeder;

    localparam int         DEPTH = 8;
    localparam logic [5:0] IDLE  = 6'b000000;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [5:0] wr_data;
    logic       start;
    logic       stop;
    logic       clear;
    logic [5:0] instr_out;
    logic       running;
    logic       done;
    logic [4:0] count;
    logic       overflow;

    int vectors    = 0;
    int miscompares = 0;

    logic [5:0] prog[$];
    logic       model_ovf;

    mccoy_instr_feeder #(
        .DEPTH      (DEPTH),
        .IDLE_INSTR (IDLE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .instr_out (instr_out),
        .running   (running),
        .done      (done),
        .count     (count),
        .overflow  (overflow)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_instr(input logic [5:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (prog.size() < DEPTH) prog.push_back(d);
        else model_ovf = 1'b1;
        vectors++;
        if ({count, overflow} !== {5'(prog.size()), model_ovf}) begin
            miscompares++;
            $display("[TB] FAIL write_status: got count=%0d ovf=%b, expected count=%0d ovf=%b",
                     count, overflow, prog.size(), model_ovf);
        end
    endtask

    task automatic clear_prog();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        prog.delete();
        model_ovf = 1'b0;
        vectors++;
        if ({count, overflow, running, done} !== {5'd0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL clear: got count=%0d ovf=%b run=%b done=%b, expected 0 0 0 0",
                     count, overflow, running, done);
        end
    endtask

    // Start a replay of the model program and follow it to its end.
    task automatic replay(input string tag);
        int n;
        n = prog.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if ({instr_out, running, done} !== {IDLE, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL %s_start: got instr=%b run=%b done=%b, expected %b 1 0",
                     tag, instr_out, running, done, IDLE);
        end
`ifdef FEEDER_LOOP_EN
        for (int j = 0; j < 3 * n + 1; j++) begin
            tick();
            vectors++;
            if ({instr_out, running, done} !== {prog[j % n], 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL %s_loop[%0d]: got instr=%b run=%b done=%b, expected %b 1 0",
                         tag, j, instr_out, running, done, prog[j % n]);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        vectors++;
        if ({instr_out, running, done} !== {IDLE, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL %s_stop: got instr=%b run=%b done=%b, expected %b 0 0",
                     tag, instr_out, running, done, IDLE);
        end
`else
        for (int j = 0; j < n; j++) begin
            tick();
            vectors++;
            if ({instr_out, running, done} !== {prog[j], 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL %s_entry[%0d]: got instr=%b run=%b done=%b, expected %b 1 0",
                         tag, j, instr_out, running, done, prog[j]);
            end
        end
        tick();
        vectors++;
        if ({instr_out, running, done} !== {IDLE, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL %s_done: got instr=%b run=%b done=%b, expected %b 0 1",
                     tag, instr_out, running, done, IDLE);
        end
`endif
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 6'b0;
        start   = 1'b0;
        stop    = 1'b0;
        clear   = 1'b0;
        prog.delete();
        model_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({instr_out, running, done, count, overflow} !== {IDLE, 1'b0, 1'b0, 5'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset: got instr=%b run=%b done=%b count=%0d ovf=%b, expected idle zeros",
                     instr_out, running, done, count, overflow);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        write_instr(6'b011000);
        write_instr(6'b010110);
        write_instr(6'b100000);
        write_instr(6'b011110);
        replay("basic");
        clear_prog();
    endtask

    task automatic test_random_programs();
        int len;
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) write_instr(6'($urandom));
            replay("rand");
            replay("rand_again");
            clear_prog();
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) write_instr(6'($urandom));
        write_instr(6'b111111);
        replay("ovf");
        clear_prog();
    endtask

    task automatic test_empty_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({instr_out, running, done, count} !== {IDLE, 1'b0, 1'b0, 5'd0}) begin
                miscompares++;
                $display("[TB] FAIL empty_start[%0d]: got instr=%b run=%b done=%b count=%0d, expected idle",
                         i, instr_out, running, done, count);
            end
            tick();
        end
    endtask

    task automatic test_stop();
        for (int i = 0; i < 3; i++) write_instr(6'($urandom));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vectors++;
        if (instr_out !== prog[1]) begin
            miscompares++;
            $display("[TB] FAIL stop_second: got %b, expected %b", instr_out, prog[1]);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({instr_out, running, done} !== {IDLE, 1'b0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL stop_idle[%0d]: got instr=%b run=%b done=%b, expected %b 0 0",
                         i, instr_out, running, done, IDLE);
            end
            tick();
        end
        replay("restart");
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({instr_out, running, done} !== {IDLE, 1'b0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL stop_start[%0d]: got instr=%b run=%b done=%b, expected %b 0 0",
                         i, instr_out, running, done, IDLE);
            end
            tick();
        end
        clear_prog();
    endtask

    task automatic test_run_ignores();
        for (int i = 0; i < 4; i++) write_instr(6'($urandom));
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en   = 1'b1;
        wr_data = 6'($urandom);
        clear   = 1'b1;
        tick();
        wr_en = 1'b0;
        clear = 1'b0;
        vectors++;
        if ({instr_out, running, count, overflow} !== {prog[0], 1'b1, 5'd4, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL run_ignore: got instr=%b run=%b count=%0d ovf=%b, expected %b 1 4 0",
                     instr_out, running, count, overflow, prog[0]);
        end
        tick();
        vectors++;
        if (instr_out !== prog[1]) begin
            miscompares++;
            $display("[TB] FAIL run_continue: got %b, expected %b", instr_out, prog[1]);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wr_en   = 1'b1;
        wr_data = 6'($urandom);
        clear   = 1'b1;
        tick();
        wr_en = 1'b0;
        clear = 1'b0;
        prog.delete();
        vectors++;
        if (count !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL clear_wins: got count=%0d, expected 0", count);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) write_instr(6'($urandom));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({instr_out, running, done, count, overflow} !== {IDLE, 1'b0, 1'b0, 5'd0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got instr=%b run=%b done=%b count=%0d ovf=%b, expected idle zeros",
                     instr_out, running, done, count, overflow);
        end
        #2 reset = 1'b0;
        prog.delete();
        model_ovf = 1'b0;
        write_instr(6'($urandom));
        clear_prog();
    endtask

`ifdef FEEDER_LOOP_EN
    task automatic test_loop();
        write_instr(6'b010000);
        write_instr(6'b010011);
        replay("loop");
        clear_prog();
    endtask
`endif

    // Scenario sequence followed by the summary line.
    initial begin
        $display("[TB] mccoy_instr_feeder bench starting");
        test_reset();
        test_basic();
        test_empty_start();
        test_random_programs();
        test_overflow();
        test_stop();
        test_run_ignores();
        test_async_reset();
`ifdef FEEDER_LOOP_EN
        test_loop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
